// File: rtl/servo_multi_slew.sv
// N-channel phase-aligned hobby-servo PWM generator with per-channel slew limiting
// and an autonomous MIN<->MAX sweep mode.
module servo_multi_slew #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PERIOD_CYC = 240000,
  parameter int unsigned PW_MIN     = 6000,
  parameter int unsigned PW_MAX     = 24000,
  parameter int unsigned STEP_DIV   = 1024,
  localparam int unsigned PW_W      = $clog2(PERIOD_CYC + 1),
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_vld,
  output logic            wr_rdy,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [PW_W-1:0] wr_pos,
  input  logic            wr_mode,
  output logic [N_CH-1:0] srv_o,
  output logic            frame_o,
  output logic [N_CH-1:0] busy_o,
  output logic            err_o
);

  localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PW_W-1:0]  FCNT_LAST = PW_W'(PERIOD_CYC - 1);
  localparam logic [PW_W-1:0]  PW_MIN_V  = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0]  PW_MAX_V  = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0]  PW_C_V    = PW_W'((PW_MIN + PW_MAX) / 2);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(STEP_DIV - 1);

  localparam logic [0:0] MODE_TRACK = 1'b0;
  localparam logic [0:0] MODE_SWEEP = 1'b1;
  localparam logic [0:0] DIR_UP     = 1'b0;
  localparam logic [0:0] DIR_DOWN   = 1'b1;

  logic [PW_W-1:0]  fcnt_q, fcnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PW_W-1:0]  cur_q [N_CH];
  logic [PW_W-1:0]  cur_d [N_CH];
  logic [PW_W-1:0]  tgt_q [N_CH];
  logic [PW_W-1:0]  tgt_d [N_CH];
  logic [PW_W-1:0]  lat_q [N_CH];
  logic [PW_W-1:0]  lat_d [N_CH];
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  dir_q, dir_d;
  logic [N_CH-1:0]  srv_d, busy_d;
  logic             frame_d, err_d;

  logic             tick, wr_acc, ch_bad, frame_end;
  logic [PW_W-1:0]  pos_clamp;

  // Next-state: counters, per-channel slew/sweep step, host write, output decode
  always_comb begin
    tick      = (pre_q == PRE_LAST);
    frame_end = (fcnt_q == FCNT_LAST);
    wr_acc    = wr_vld & wr_rdy;
    ch_bad    = (32'(wr_ch) >= N_CH);

    if (wr_pos < PW_MIN_V)      pos_clamp = PW_MIN_V;
    else if (wr_pos > PW_MAX_V) pos_clamp = PW_MAX_V;
    else                        pos_clamp = wr_pos;

    fcnt_d  = frame_end ? '0 : fcnt_q + PW_W'(1);
    pre_d   = tick ? '0 : pre_q + PRE_W'(1);
    frame_d = (fcnt_q == '0);
    err_d   = wr_acc & ch_bad;
    mode_d  = mode_q;
    dir_d   = dir_q;
    srv_d   = '0;
    busy_d  = '0;

    for (int i = 0; i < int'(N_CH); i++) begin
      cur_d[i] = cur_q[i];
      tgt_d[i] = tgt_q[i];
      lat_d[i] = frame_end ? cur_q[i] : lat_q[i];

      // Step uses pre-write tgt/mode; a same-cycle write applies from the next tick
      if (tick) begin
        if (mode_q[i] == MODE_TRACK) begin
          if (cur_q[i] < tgt_q[i])      cur_d[i] = cur_q[i] + PW_W'(1);
          else if (cur_q[i] > tgt_q[i]) cur_d[i] = cur_q[i] - PW_W'(1);
        end else if (dir_q[i] == DIR_UP) begin
          if (cur_q[i] >= PW_MAX_V) begin
            dir_d[i] = DIR_DOWN;
            cur_d[i] = PW_MAX_V - PW_W'(1);
          end else begin
            cur_d[i] = cur_q[i] + PW_W'(1);
          end
        end else begin
          if (cur_q[i] <= PW_MIN_V) begin
            dir_d[i] = DIR_UP;
            cur_d[i] = PW_MIN_V + PW_W'(1);
          end else begin
            cur_d[i] = cur_q[i] - PW_W'(1);
          end
        end
      end

      if (wr_acc && !ch_bad && (wr_ch == CH_W'(i))) begin
        tgt_d[i]  = pos_clamp;
        mode_d[i] = wr_mode;
        if ((mode_q[i] == MODE_TRACK) && (wr_mode == MODE_SWEEP))
          dir_d[i] = (cur_d[i] < PW_MAX_V) ? DIR_UP : DIR_DOWN;
      end

      srv_d[i]  = (fcnt_q < lat_q[i]);
      busy_d[i] = (mode_d[i] == MODE_TRACK) && (cur_d[i] != tgt_d[i]);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q  <= '0;
      pre_q   <= '0;
      mode_q  <= {N_CH{MODE_TRACK}};
      dir_q   <= {N_CH{DIR_UP}};
      srv_o   <= '0;
      busy_o  <= '0;
      frame_o <= 1'b0;
      err_o   <= 1'b0;
      wr_rdy  <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cur_q[i] <= PW_C_V;
        tgt_q[i] <= PW_C_V;
        lat_q[i] <= PW_C_V;
      end
    end else begin
      fcnt_q  <= fcnt_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      srv_o   <= srv_d;
      busy_o  <= busy_d;
      frame_o <= frame_d;
      err_o   <= err_d;
      wr_rdy  <= 1'b1;
      for (int i = 0; i < int'(N_CH); i++) begin
        cur_q[i] <= cur_d[i];
        tgt_q[i] <= tgt_d[i];
        lat_q[i] <= lat_d[i];
      end
    end
  end

endmodule

// File: tb/tb_servo_multi_slew.sv
// Directed bench for servo_multi_slew: N_CH=3 (so an out-of-range channel index is
// encodable), PERIOD_CYC=100, PW_MIN=10, PW_MAX=40, STEP_DIV=4, PW_C=25.
module tb_servo_multi_slew;

  localparam int unsigned N_CH       = 3;
  localparam int unsigned PERIOD_CYC = 100;
  localparam int unsigned PW_MIN     = 10;
  localparam int unsigned PW_MAX     = 40;
  localparam int unsigned STEP_DIV   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_vld = 1'b0;
  logic       wr_rdy;
  logic [1:0] wr_ch = '0;
  logic [6:0] wr_pos = '0;
  logic       wr_mode = 1'b0;
  logic [2:0] srv_o;
  logic       frame_o;
  logic [2:0] busy_o;
  logic       err_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int cnt_a, cnt_b;

  servo_multi_slew #(
    .N_CH(N_CH), .PERIOD_CYC(PERIOD_CYC), .PW_MIN(PW_MIN),
    .PW_MAX(PW_MAX), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_ch(wr_ch),
    .wr_pos(wr_pos), .wr_mode(wr_mode), .srv_o(srv_o), .frame_o(frame_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Posedge index since reset release; frames start at cyc = 100k+1, ticks at cyc % 4 == 0
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("wait_cyc_%0d", target), 32'(cyc), 32'(target));
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [6:0] pos, input logic mode);
    wr_vld  = 1'b1;
    wr_ch   = ch;
    wr_pos  = pos;
    wr_mode = mode;
    @(negedge clk);
    wr_vld  = 1'b0;
  endtask

  // Measures one frame starting at cycle `start`; a non-contiguous pulse reports width -1
  task automatic measure(input int start, input int e0, input int e1, input int e2, input string tag);
    int w[3];
    bit fell[3];
    bit bad[3];
    int exp_w[3];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2;
    for (int c = 0; c < 3; c++) begin
      w[c] = 0; fell[c] = 1'b0; bad[c] = 1'b0;
    end
    wait_cyc(start);
    chk({tag, "_frame_start"}, 32'(frame_o), 32'd1);
    for (int k = 0; k < int'(PERIOD_CYC); k++) begin
      for (int c = 0; c < 3; c++) begin
        if (srv_o[c]) begin
          if (fell[c]) bad[c] = 1'b1;
          w[c]++;
        end else begin
          fell[c] = 1'b1;
        end
      end
      @(negedge clk);
    end
    chk({tag, "_period"}, 32'(frame_o), 32'd1);
    for (int c = 0; c < 3; c++)
      chk($sformatf("%s_w%0d", tag, c), bad[c] ? 32'hFFFF_FFFF : 32'(w[c]), 32'(exp_w[c]));
  endtask

  // Counts cycles with busy_o[ch] high, and cycles where any other busy bit is high
  task automatic count_busy(input int ch, input int n, output int cnt_ch, output int cnt_other);
    cnt_ch = 0;
    cnt_other = 0;
    for (int k = 0; k < n; k++) begin
      if (busy_o[ch]) cnt_ch++;
      if ((busy_o & ~(3'b001 << ch)) != 3'b000) cnt_other++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_srv",   32'(srv_o),   32'd0);
    chk("rst_frame", 32'(frame_o), 32'd0);
    chk("rst_busy",  32'(busy_o),  32'd0);
    chk("rst_err",   32'(err_o),   32'd0);
    chk("rst_rdy",   32'(wr_rdy),  32'd0);

    // 1: release, idle frame at centre width
    rst = 1'b0;
    #1;
    chk("rdy_at_release", 32'(wr_rdy), 32'd0);
    @(negedge clk);
    chk("rdy_after_1", 32'(wr_rdy), 32'd1);
    measure(1, 25, 25, 25, "t1_f1");

    // 2: ch0 -> 35 on a tick cycle; 10 steps x 4 cycles of busy
    wait_cyc(103);
    do_write(2'd0, 7'd35, 1'b0);
    chk("t2_no_err", 32'(err_o), 32'd0);
    count_busy(0, 60, cnt_a, cnt_b);
    chk("t2_busy0_cycles", 32'(cnt_a), 32'd40);
    chk("t2_busy_other",   32'(cnt_b), 32'd0);
    measure(201, 35, 25, 25, "t2_f201");

    // 3: ch1 clamp high then low
    wait_cyc(303);
    do_write(2'd1, 7'd120, 1'b0);
    chk("t3_busy1", 32'(busy_o), 32'd2);
    measure(401, 35, 40, 25, "t3_f401");
    wait_cyc(503);
    do_write(2'd1, 7'd0, 1'b0);
    measure(601, 35, 17, 25, "t3_f601");
    measure(701, 35, 10, 25, "t3_f701");

    // 4: ch0 sweep from 35: peak 40 @824, floor 10 @944, peak 40 @1064
    wait_cyc(803);
    do_write(2'd0, 7'd35, 1'b1);
    chk("t4_busy_sweep", 32'(busy_o), 32'd0);
    measure(901, 22, 10, 25, "t4_f901");
    chk("t4_busy_mid", 32'(busy_o), 32'd0);
    measure(1001, 23, 10, 25, "t4_f1001");
    measure(1101, 32, 10, 25, "t4_f1101");

    // 5: out-of-range channel
    wait_cyc(1203);
    do_write(2'd3, 7'd30, 1'b1);
    chk("t5_err_pulse", 32'(err_o), 32'd1);
    @(negedge clk);
    chk("t5_err_clear", 32'(err_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    measure(1301, 38, 10, 25, "t5_f1301");

    // 6: ch0 back to track on a tick; that tick still sweeps 16->15, then 5 steps to 20
    wait_cyc(1403);
    do_write(2'd0, 7'd20, 1'b0);
    count_busy(0, 60, cnt_a, cnt_b);
    chk("t6_busy0_cycles", 32'(cnt_a), 32'd20);
    chk("t6_busy_other",   32'(cnt_b), 32'd0);

    wait_cyc(1505);
    chk("t6_pulse_high", 32'(srv_o), 32'd7);
    rst = 1'b1;
    #1;
    chk("t6_rst_srv",   32'(srv_o),   32'd0);
    chk("t6_rst_frame", 32'(frame_o), 32'd0);
    chk("t6_rst_rdy",   32'(wr_rdy),  32'd0);
    chk("t6_rst_busy",  32'(busy_o),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rdy_after", 32'(wr_rdy), 32'd1);
    measure(1, 25, 25, 25, "t6_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
